// File: rtl/id_ex_if.sv
// id_ex_if: decode-to-execute bus with MEM/WB forwarding sources, ALU operands and debug counters
interface id_ex_if #(
    parameter int XLEN = 32,
    parameter int CNT_W = 16
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [4:0]      id_rs1_addr;
    logic [4:0]      id_rs2_addr;
    logic [4:0]      id_rd_addr;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_alu_ctrl;
    logic            id_a_sel;
    logic            id_b_sel;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            ex_flush;
    logic            mem_reg_write;
    logic [4:0]      mem_rd_addr;
    logic [XLEN-1:0] mem_result;
    logic            wb_reg_write;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_result;
    logic            id_stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rd_addr;
    logic [4:0]      ex_alu_ctrl;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_ctrl, id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write,
               ex_flush, mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
        input  id_stall, ex_valid, ex_pc, ex_rd_addr, ex_alu_ctrl, ex_a, ex_b, ex_store_data,
               ex_reg_write, ex_mem_read, ex_mem_write, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
               id_imm, id_alu_ctrl, id_a_sel, id_b_sel, id_reg_write, id_mem_read, id_mem_write,
               ex_flush, mem_reg_write, mem_rd_addr, mem_result, wb_reg_write, wb_rd_addr, wb_result,
        output id_stall, ex_valid, ex_pc, ex_rd_addr, ex_alu_ctrl, ex_a, ex_b, ex_store_data,
               ex_reg_write, ex_mem_read, ex_mem_write, stall_count, flush_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush, MEM/WB forwarding and stall/flush counters
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int CNT_W = 16,
    parameter bit FWD_EN = 1'b1
) (
    input logic clk,
    input logic rst_n,
    id_ex_if.slave bus
);
    logic             v, a_sel, b_sel, rw, mr, mw, stall;
    logic [XLEN-1:0]  pc, rs1_d, rs2_d, imm, rs1_cap, rs2_cap, rs1_fwd, rs2_fwd;
    logic [4:0]       rs1, rs2, rd, ctrl;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    function automatic logic hit(input logic we, input logic [4:0] w, input logic [4:0] r);
        return we && w != 5'd0 && w == r;
    endfunction

    always_comb begin
        stall = bus.id_valid && v && mr && rd != 5'd0 && !bus.ex_flush &&
                (rd == bus.id_rs1_addr || rd == bus.id_rs2_addr);
        rs1_cap = hit(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs1_addr) ? bus.wb_result : bus.id_rs1_data;
        rs2_cap = hit(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs2_addr) ? bus.wb_result : bus.id_rs2_data;
        rs1_fwd = FWD_EN && hit(bus.mem_reg_write, bus.mem_rd_addr, rs1) ? bus.mem_result :
                  FWD_EN && hit(bus.wb_reg_write, bus.wb_rd_addr, rs1) ? bus.wb_result : rs1_d;
        rs2_fwd = FWD_EN && hit(bus.mem_reg_write, bus.mem_rd_addr, rs2) ? bus.mem_result :
                  FWD_EN && hit(bus.wb_reg_write, bus.wb_rd_addr, rs2) ? bus.wb_result : rs2_d;
    end

    assign bus.id_stall      = stall;
    assign bus.ex_valid      = v;
    assign bus.ex_pc         = pc;
    assign bus.ex_rd_addr    = rd;
    assign bus.ex_alu_ctrl   = ctrl;
    assign bus.ex_a          = a_sel ? pc : rs1_fwd;
    assign bus.ex_b          = b_sel ? imm : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_reg_write  = v & rw;
    assign bus.ex_mem_read   = v & mr;
    assign bus.ex_mem_write  = v & mw;
    assign bus.stall_count   = stall_cnt;
    assign bus.flush_count   = flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v         <= 1'b0;
            pc        <= '0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            rs1_d     <= '0;
            rs2_d     <= '0;
            imm       <= '0;
            ctrl      <= '0;
            a_sel     <= 1'b0;
            b_sel     <= 1'b0;
            rw        <= 1'b0;
            mr        <= 1'b0;
            mw        <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + CNT_W'(stall && !(&stall_cnt));
            flush_cnt <= flush_cnt + CNT_W'(bus.ex_flush && !(&flush_cnt));
            if (bus.ex_flush || stall) begin
                v <= 1'b0;
            end else begin
                v     <= bus.id_valid;
                pc    <= bus.id_pc;
                rs1   <= bus.id_rs1_addr;
                rs2   <= bus.id_rs2_addr;
                rd    <= bus.id_rd_addr;
                rs1_d <= rs1_cap;
                rs2_d <= rs2_cap;
                imm   <= bus.id_imm;
                ctrl  <= bus.id_alu_ctrl;
                a_sel <= bus.id_a_sel;
                b_sel <= bus.id_b_sel;
                rw    <= bus.id_reg_write;
                mr    <= bus.id_mem_read;
                mw    <= bus.id_mem_write;
            end
        end
    end
endmodule
